// File: rtl/zed64_vram_pkg.sv
// Shared definitions for the CPU-side video RAM bridge.
//   - CPU memory-map region bases (font, attr, cell)
//   - ram_sel encodings
//   - read FSM state enum
//   - write FIFO entry struct
//   - address decode helpers used by the bridge
package zed64_vram_pkg;

  localparam logic [15:0] FONT_BASE = 16'h7000;
  localparam logic [15:0] ATTR_BASE = 16'h8000;
  localparam logic [15:0] CELL_BASE = 16'hC000;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_FONT = 2'b01,
    SEL_ATTR = 2'b10,
    SEL_CELL = 2'b11
  } ram_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_DATA,
    ST_DONE
  } rd_state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  function automatic ram_sel_e decode_sel(input logic [15:0] a);
    if (a >= CELL_BASE)      return SEL_CELL;
    else if (a >= ATTR_BASE) return SEL_ATTR;
    else if (a >= FONT_BASE) return SEL_FONT;
    else                     return SEL_NONE;
  endfunction

  // Font RAM is only 4K deep; attr and cell use the low 14 address bits.
  function automatic logic [13:0] decode_addr(input logic [15:0] a);
    if (decode_sel(a) == SEL_FONT) return {2'b00, a[11:0]};
    else                           return a[13:0];
  endfunction

endpackage

// File: rtl/vram_cpu_port_if.sv
// CPU bus into the video RAM bridge.
//   cpu_addr/cpu_dataw/cpu_wr/cpu_rd : driven by the CPU (master)
//   cpu_datar/cpu_rdy                : driven by the bridge (slave)
interface vram_cpu_port_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dataw;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_datar;
  logic        cpu_rdy;

  modport master (
    output cpu_addr, cpu_dataw, cpu_wr, cpu_rd,
    input  cpu_datar, cpu_rdy
  );

  modport slave (
    input  cpu_addr, cpu_dataw, cpu_wr, cpu_rd,
    output cpu_datar, cpu_rdy
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO for the video RAM bridge.
//   cpu_clk, act_reset : clock, async active-high reset
//   push, din          : enqueue one entry (ignored when full)
//   pop, dout          : dequeue head entry (ignored when empty); dout shows head
//   full, empty, count : occupancy, count range 0..DEPTH
module vram_wr_fifo
  import zed64_vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      cpu_clk,
  input  logic      act_reset,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty,
  output logic [4:0] count
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == 5'(DEPTH));
  assign empty   = (count == 5'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is not reset; the count alone decides what is valid,
  // which keeps the array free of reset fan-out.
  always_ff @(posedge cpu_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge cpu_clk or posedge act_reset) begin
    if (act_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_cpu_port.sv
// CPU-side (port A) bridge into the video RAMs.
//   cpu_clk, act_reset   : clock, async active-high reset
//   bus (slave)          : CPU address/data/strobes, read data and ready
//   vram_hit             : CPU address falls in 0x7000-0xFFFF
//   vblank_async         : vertical blank from the pixel clock domain
//   blank_only           : restrict write draining to vertical blank
//   ram_sel/addr/wdata   : port-A RAM select, word address, write data
//   ram_we / ram_re      : one-cycle write / read enables
//   ram_rdata            : synchronous RAM read data (one cycle after ram_re)
//   fifo_level           : write buffer occupancy
// Writes are buffered and drained one per cycle; reads wait for every
// earlier write to drain so the CPU always reads back its own data.
module vram_cpu_port
  import zed64_vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = 14
) (
  input  logic                 cpu_clk,
  input  logic                 act_reset,
  vram_cpu_port_if.slave       bus,
  output logic                 vram_hit,
  input  logic                 vblank_async,
  input  logic                 blank_only,
  output logic [1:0]           ram_sel,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_we,
  output logic                 ram_re,
  input  logic [7:0]           ram_rdata,
  output logic [4:0]           fifo_level
);

  rd_state_e   state_q, state_d;
  ram_sel_e    acc_sel;
  logic [13:0] acc_addr;
  logic        vb_m, vb_s;
  logic        fifo_full, fifo_empty;
  logic        push, drain_ok;
  wr_entry_t   fifo_din, fifo_dout;

  assign vram_hit = (bus.cpu_addr[15:12] >= 4'h7);
  assign acc_sel  = decode_sel(bus.cpu_addr);
  assign acc_addr = decode_addr(bus.cpu_addr);

  assign fifo_din = '{sel: acc_sel, addr: acc_addr, data: bus.cpu_dataw};
  // A full FIFO never accepts a push, even when a pop frees a slot the same cycle.
  assign push     = vram_hit && bus.cpu_wr && !fifo_full;
  assign drain_ok = !fifo_empty && (!blank_only || vb_s);

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .cpu_clk   (cpu_clk),
    .act_reset (act_reset),
    .push      (push),
    .din       (fifo_din),
    .pop       (drain_ok),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge cpu_clk or posedge act_reset) begin
    if (act_reset) begin
      vb_m <= 1'b0;
      vb_s <= 1'b0;
    end else begin
      vb_m <= vblank_async;
      vb_s <= vb_m;
    end
  end

  always_ff @(posedge cpu_clk or posedge act_reset) begin
    if (act_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    bus.cpu_rdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.cpu_rdy = !(vram_hit && (bus.cpu_rd || (bus.cpu_wr && fifo_full)));
        if (vram_hit && bus.cpu_rd) state_d = fifo_empty ? ST_ISSUE : ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA:  state_d = ST_DONE;
      ST_DONE: begin
        bus.cpu_rdy = 1'b1;
        state_d     = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM port is fully registered. A drain and a read issue cannot coincide:
  // the read is only issued once the FIFO is empty.
  always_ff @(posedge cpu_clk or posedge act_reset) begin
    if (act_reset) begin
      ram_we        <= 1'b0;
      ram_re        <= 1'b0;
      ram_sel       <= SEL_NONE;
      ram_addr      <= '0;
      ram_wdata     <= 8'h00;
      bus.cpu_datar <= 8'h00;
    end else begin
      ram_we  <= 1'b0;
      ram_re  <= 1'b0;
      ram_sel <= SEL_NONE;
      if (drain_ok) begin
        ram_we    <= 1'b1;
        ram_sel   <= fifo_dout.sel;
        ram_addr  <= RAM_AW'(fifo_dout.addr);
        ram_wdata <= fifo_dout.data;
      end else if (state_d == ST_ISSUE) begin
        ram_re   <= 1'b1;
        ram_sel  <= acc_sel;
        ram_addr <= RAM_AW'(acc_addr);
      end
      if (state_q == ST_DATA) bus.cpu_datar <= ram_rdata;
    end
  end

endmodule
